// File: rtl/exec_unit.sv
// Sequenced single-instruction execution unit driving an external register file.
// Define EXEC_UNIT_MUL_EN to build the 16-cycle shift-add multiplier; otherwise opcode 111 is a NOP.
module exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [2:0]  ra,
    input  logic [2:0]  rb,
    output logic        busy,
    output logic        done,
    output logic [2:0]  rf_addr_a,
    output logic [2:0]  rf_addr_b,
    output logic        rf_we,
    output logic [15:0] rf_wdata,
    input  logic [15:0] rf_data_a,
    input  logic [15:0] rf_data_b,
    output logic        flag_zero,
    output logic        flag_carry
);

    // state | meaning
    // IDLE  | waiting for start
    // ADDR  | register-file read in flight
    // EXEC  | ALU evaluates, or multiplier is loaded
    // MUL   | one shift-add step per cycle
    // WB    | write-back pulse, flags valid
    typedef enum logic [2:0] {IDLE, ADDR, EXEC, MUL, WB} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [2:0]  addr_a_q, addr_a_d;
    logic [2:0]  addr_b_q, addr_b_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;

`ifdef EXEC_UNIT_MUL_EN
    logic [31:0] prod_q, prod_d;
    logic [31:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] prod_next;
`endif

    logic [15:0] alu_res;
    logic        alu_c;
    logic [16:0] sum_w;
    logic [16:0] shl_w;
    logic [16:0] shr_w;

    // Bit 16 of the shift-left word and bit 0 of the shift-right word hold the last bit shifted out.
    always_comb begin
        sum_w   = {1'b0, rf_data_a} + {1'b0, rf_data_b};
        shl_w   = {1'b0, rf_data_a} << rf_data_b[3:0];
        shr_w   = {rf_data_a, 1'b0} >> rf_data_b[3:0];
        alu_res = 16'h0000;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: begin alu_res = sum_w[15:0];             alu_c = sum_w[16]; end
            OP_SUB: begin alu_res = rf_data_a - rf_data_b;   alu_c = (rf_data_a < rf_data_b); end
            OP_AND: alu_res = rf_data_a & rf_data_b;
            OP_OR:  alu_res = rf_data_a | rf_data_b;
            OP_XOR: alu_res = rf_data_a ^ rf_data_b;
            OP_SHL: begin alu_res = shl_w[15:0];             alu_c = shl_w[16]; end
            OP_SHR: begin alu_res = shr_w[16:1];             alu_c = shr_w[0]; end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        zero_d   = zero_q;
        carry_d  = carry_q;
`ifdef EXEC_UNIT_MUL_EN
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        prod_next = prod_q + (mplier_q[0] ? mcand_q : 32'h0);
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = opcode;
                    addr_a_d = ra;
                    addr_b_d = rb;
                    state_d  = ADDR;
                end
            end
            ADDR: state_d = EXEC;
            EXEC: begin
                if (op_q == 3'b111) begin
`ifdef EXEC_UNIT_MUL_EN
                    prod_d   = 32'h0;
                    mcand_d  = {16'h0000, rf_data_a};
                    mplier_d = rf_data_b;
                    cnt_d    = 4'd15;
                    state_d  = MUL;
`else
                    done_d  = 1'b1;
                    state_d = WB;
`endif
                end else begin
                    wdata_d = alu_res;
                    zero_d  = (alu_res == 16'h0000);
                    carry_d = alu_c;
                    we_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = WB;
                end
            end
`ifdef EXEC_UNIT_MUL_EN
            MUL: begin
                prod_d   = prod_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == 4'd0) begin
                    wdata_d = prod_next[15:0];
                    zero_d  = (prod_next[15:0] == 16'h0000);
                    carry_d = |prod_next[31:16];
                    we_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 3'b000;
            addr_a_q <= 3'b000;
            addr_b_q <= 3'b000;
            wdata_q  <= 16'h0000;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
`ifdef EXEC_UNIT_MUL_EN
            prod_q   <= 32'h0;
            mcand_q  <= 32'h0;
            mplier_q <= 16'h0000;
            cnt_q    <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
`ifdef EXEC_UNIT_MUL_EN
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rf_addr_a  = addr_a_q;
    assign rf_addr_b  = addr_b_q;
    assign rf_we      = we_q;
    assign rf_wdata   = wdata_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit with a behavioural one-cycle-latency register file.
module tb_exec_unit;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  opcode, ra, rb;
    logic        busy, done, rf_we, flag_zero, flag_carry;
    logic [2:0]  rf_addr_a, rf_addr_b;
    logic [15:0] rf_wdata, rf_data_a, rf_data_b;

    exec_unit dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .ra(ra), .rb(rb),
        .busy(busy), .done(done), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .flag_zero(flag_zero), .flag_carry(flag_carry)
    );

    always #5 clk = ~clk;

    logic [15:0] regs [8];
    always @(posedge clk) begin
        rf_data_a <= regs[rf_addr_a];
        rf_data_b <= regs[rf_addr_b];
        if (rf_we) regs[rf_addr_a] <= rf_wdata;
    end

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        z;
        logic        c;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    logic mz = 1'b0, mc = 1'b0;

`ifdef EXEC_UNIT_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    endtask

    function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic c, output logic we);
        logic [31:0] t;
        int n;
        n  = int'(b[3:0]);
        we = 1'b1;
        c  = 1'b0;
        r  = 16'h0;
        case (op)
            3'd0: begin t = {16'h0, a} + {16'h0, b}; r = t[15:0]; c = t[16]; end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = a << n; c = (n == 0) ? 1'b0 : a[16 - n]; end
            3'd6: begin r = a >> n; c = (n == 0) ? 1'b0 : a[n - 1]; end
            default: begin
                if (MUL_EN) begin t = {16'h0, a} * {16'h0, b}; r = t[15:0]; c = |t[31:16]; end
                else we = 1'b0;
            end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [2:0] ra_i, input logic [2:0] rb_i,
                          input logic [15:0] a, input logic [15:0] b, input bit poke);
        exp_t        e, g;
        logic [15:0] r, b_eff;
        logic        c, we;
        int          cyc;
        bit          got, stab;
        b_eff = (ra_i == rb_i) ? a : b;
        model(op, a, b_eff, r, c, we);
        e.we   = we;
        e.addr = ra_i;
        e.data = r;
        e.z    = we ? (r == 16'h0) : mz;
        e.c    = we ? c : mc;
        e.lat  = (op == 3'b111 && MUL_EN) ? 19 : 3;
        mz = e.z;
        mc = e.c;
        @(negedge clk);
        regs[ra_i] <= a;
        if (rb_i != ra_i) regs[rb_i] <= b;
        sb.push_back(e);
        start = 1'b1; opcode = op; ra = ra_i; rb = rb_i;
        cyc = 0; got = 0; stab = 1;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 1) begin
                start = 1'b1; opcode = 3'd0; ra = ~ra_i; rb = ~rb_i;
            end else start = 1'b0;
            if (rf_addr_a != ra_i || rf_addr_b != rb_i) stab = 0;
            if (done) got = 1;
        end
        if (!got) check("done_timeout", 32'(cyc), 32'(e.lat));
        if (sb.size() == 0) check("sb_empty", 0, 1);
        else begin
            g = sb.pop_front();
            if (got) begin
                check("latency", 32'(cyc), 32'(g.lat));
                check("rf_we", 32'(rf_we), 32'(g.we));
                check("busy_wb", 32'(busy), 1);
                check("addr_stable", 32'(stab), 1);
                if (g.we) check("wdata", 32'(rf_wdata), 32'(g.data));
                check("flag_zero", 32'(flag_zero), 32'(g.z));
                check("flag_carry", 32'(flag_carry), 32'(g.c));
            end
        end
        @(negedge clk);
        check("idle_after", {30'h0, busy, done}, 0);
        if (poke) begin
            got = 0;
            repeat (4) begin
                @(negedge clk);
                if (busy || done || rf_we) got = 1;
            end
            check("start_ignored", 32'(got), 0);
            check("flags_hold", {30'h0, flag_zero, flag_carry}, {30'h0, mz, mc});
        end
    endtask

    initial begin
        bit we_seen;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0;
        rst = 1'b1; start = 1'b0; opcode = 3'd0; ra = 3'd0; rb = 3'd0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, rf_we, flag_zero, flag_carry, rf_addr_a, rf_addr_b, rf_wdata}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_start", 32'(busy), 0);

        run_op(3'd0, 3'd1, 3'd2, 16'hFFFF, 16'h0001, 0);
        run_op(3'd1, 3'd1, 3'd2, 16'h0003, 16'h0005, 0);
        run_op(3'd5, 3'd3, 3'd4, 16'h8001, 16'h0001, 0);
        run_op(3'd6, 3'd3, 3'd4, 16'h8001, 16'h0000, 0);
        run_op(3'd6, 3'd5, 3'd6, 16'h00F8, 16'h0004, 0);
        run_op(3'd5, 3'd5, 3'd6, 16'h4000, 16'h000F, 0);
        run_op(3'd2, 3'd0, 3'd7, 16'hF0F0, 16'h3C3C, 0);
        run_op(3'd3, 3'd0, 3'd7, 16'hF0F0, 16'h0F0F, 1);
        run_op(3'd4, 3'd6, 3'd6, 16'h1234, 16'h0000, 0);
        run_op(3'd0, 3'd2, 3'd2, 16'h1234, 16'h0000, 0);
        run_op(3'd7, 3'd1, 3'd2, 16'h0100, 16'h0100, 0);
        run_op(3'd7, 3'd3, 3'd4, 16'h0007, 16'h0009, 0);
        run_op(3'd7, 3'd5, 3'd6, 16'hFFFF, 16'hFFFF, 1);

        // Abort mid-operation (inside MUL when the multiplier is built).
        @(negedge clk);
        regs[4] <= 16'h0100; regs[5] <= 16'h0100;
        start = 1'b1; opcode = MUL_EN ? 3'd7 : 3'd0; ra = 3'd4; rb = 3'd5;
        we_seen = 0;
        repeat (MUL_EN ? 6 : 2) begin
            @(negedge clk);
            start = 1'b0;
            if (rf_we) we_seen = 1;
        end
        check("busy_before_abort", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", {busy, done, rf_we, flag_zero, flag_carry, rf_addr_a, rf_addr_b, rf_wdata}, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rf_we || busy || done) we_seen = 1;
        end
        check("abort_no_write", 32'(we_seen), 0);
        mz = 1'b0; mc = 1'b0;

        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("rst_over_start", 32'(busy), 0);
        rst = 1'b0; start = 1'b0;

        run_op(3'd1, 3'd7, 3'd0, 16'h0005, 16'h0005, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port start  input  1  request to execute one instruction; sampled only in IDLE.
REQ-004 SHALL have port opcode  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
REQ-005 SHALL have port ra  input  3  destination and first-source register index.
REQ-006 SHALL have port rb  input  3  second-source register index.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  single-cycle pulse; writeback in progress.
REQ-009 SHALL have port rf_addr_a  output  3  register-file port A address; also the write address.
REQ-010 SHALL have port rf_addr_b  output  3  register-file port B address.
REQ-011 SHALL have port rf_we  output  1  register-file write enable.
REQ-012 SHALL have port rf_wdata  output  16  register-file write data.
REQ-013 SHALL have port rf_data_a  input  16  register-file read data A; valid one cycle after its address is presented.
REQ-014 SHALL have port rf_data_b  input  16  register-file read data B; same one-cycle latency.
REQ-015 SHALL have port flag_zero  output  1  result of last completed op was zero.
REQ-016 SHALL have port flag_carry  output  1  carry/borrow/shift-out of last completed op.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, EXEC, MUL, WB; all outputs registered.
REQ-018 IDLE: start=1 SHALL latch opcode, ra, rb; drive rf_addr_a=ra, rf_addr_b=rb; go to ADDR. start=0 keeps IDLE.
REQ-019 ADDR SHALL last exactly one cycle (register-file read latency), then go to EXEC.
REQ-020 EXEC: non-MUL opcodes SHALL compute the result from rf_data_a (A) and rf_data_b (B), load it into rf_wdata, and go to WB; MUL goes to MUL.
REQ-021 Arithmetic: ADD = A+B mod 2^16, carry = bit 16; SUB = A-B mod 2^16, carry = 1 iff A<B unsigned; AND/OR/XOR carry = 0.
REQ-022 Shifts: amount = B[3:0]; SHL carry = last bit shifted out of bit 15; SHR carry = last bit shifted out of bit 0; amount 0 gives result A, carry 0.
REQ-023 MUL SHALL be iterative shift-add over exactly 16 cycles with a 32-bit product; rf_wdata = product[15:0]; carry = OR of product[31:16]; then go to WB.
REQ-024 WB SHALL last one cycle with rf_we=1 and done=1, update flag_zero (rf_wdata==0) and flag_carry, then return to IDLE.
REQ-025 Latency SHALL be: done asserted 3 cycles after the accepting edge for non-MUL ops, 19 cycles for MUL.
REQ-026 rf_addr_a and rf_addr_b SHALL remain stable from the accepting edge through the end of WB.
REQ-027 start while busy=1 SHALL be ignored, with no queueing.
REQ-028 rf_we SHALL be 1 only in WB; flags SHALL hold their values outside WB.
REQ-029 ra==rb SHALL be legal, with A==B.

Reset
REQ-030 rst=1 SHALL force, on the next edge: state IDLE; busy, done, rf_we, flag_zero, flag_carry = 0; rf_addr_a, rf_addr_b, rf_wdata = 0.
REQ-031 rst asserted during an operation SHALL abort it with no register-file write; rst takes priority over start.

Configuration
REQ-032 Macro EXEC_UNIT_MUL_EN defined SHALL include the MUL state and multiplier datapath.
REQ-033 Without EXEC_UNIT_MUL_EN, opcode 111 SHALL go from EXEC directly to WB with rf_we=0, done=1 and flags unchanged (NOP, latency 3).

Verification
REQ-034 Preload A=0xFFFF, B=0x0001, ADD ra=1 rb=2 -> done at cycle 3, rf_we writes 0x0000 to reg 1, flag_zero=1, flag_carry=1.
REQ-035 A=0x0003, B=0x0005, SUB -> writes 0xFFFE, flag_carry=1, flag_zero=0.
REQ-036 A=0x8001, B=0x0001, SHL -> writes 0x0002, flag_carry=1; SHR with B=0x0000 -> writes 0x8001, flag_carry=0.
REQ-037 With EXEC_UNIT_MUL_EN, A=0x0100, B=0x0100 MUL -> done at cycle 19, writes 0x0000, flag_carry=1; without it -> done at cycle 3, rf_we=0.
REQ-038 Pulse start during busy -> ignored; assert rst in MUL -> next cycle busy=0, rf_we never asserted, all outputs 0.
